// File: rtl/demux_32.sv
// rtl/demux_32.sv - 32-bit 1:2 stream demux with a 2-entry FIFO and a push counter per channel

module demux_32_fifo2 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] wdata,
    output logic        valid,
    output logic        full,
    output logic [31:0] rdata
);
    logic [31:0] mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic        push_ok;
    logic        pop_ok;

    assign valid   = (count != 2'd0);
    assign full    = (count == 2'd2);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & valid;
    // Empty FIFO presents zero so stale entries never leak onto the bus.
    assign rdata   = valid ? mem[rd_ptr] : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= 32'h0;
            mem[1] <= 32'h0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (clr) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end
endmodule

module demux_32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        sel,
    output logic        out_a_valid,
    input  logic        out_a_ready,
    output logic [31:0] out_a_data,
    output logic        out_b_valid,
    input  logic        out_b_ready,
    output logic [31:0] out_b_data,
    output logic [15:0] cnt_a,
    output logic [15:0] cnt_b
);
    logic a_full;
    logic b_full;
    logic push;
    logic push_a;
    logic push_b;
    logic pop_a;
    logic pop_b;

    // Ready depends only on the selected channel, so a full B never blocks traffic to A.
    assign in_ready = rst_n & ~flush & ~(sel ? b_full : a_full);
    assign push     = in_valid & in_ready;
    assign push_a   = push & ~sel;
    assign push_b   = push & sel;
    assign pop_a    = out_a_valid & out_a_ready & ~flush;
    assign pop_b    = out_b_valid & out_b_ready & ~flush;

    demux_32_fifo2 u_fifo_a (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .push  (push_a),
        .pop   (pop_a),
        .wdata (in_data),
        .valid (out_a_valid),
        .full  (a_full),
        .rdata (out_a_data)
    );

    demux_32_fifo2 u_fifo_b (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .push  (push_b),
        .pop   (pop_b),
        .wdata (in_data),
        .valid (out_b_valid),
        .full  (b_full),
        .rdata (out_b_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a <= 16'h0;
            cnt_b <= 16'h0;
        end else if (flush) begin
            cnt_a <= 16'h0;
            cnt_b <= 16'h0;
        end else begin
            if (push_a) cnt_a <= cnt_a + 16'd1;
            if (push_b) cnt_b <= cnt_b + 16'd1;
        end
    end
endmodule

// File: tb/tb_demux_32.sv
// tb/tb_demux_32.sv - randomized and directed bench for demux_32 against a queue model
`timescale 1ns/1ps

module tb_demux_32;
    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        sel;
    logic        out_a_valid;
    logic        out_a_ready;
    logic [31:0] out_a_data;
    logic        out_b_valid;
    logic        out_b_ready;
    logic [31:0] out_b_data;
    logic [15:0] cnt_a;
    logic [15:0] cnt_b;

    int tot;
    int bad;

    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [15:0] ma;
    logic [15:0] mb;

    demux_32 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .sel         (sel),
        .out_a_valid (out_a_valid),
        .out_a_ready (out_a_ready),
        .out_a_data  (out_a_data),
        .out_b_valid (out_b_valid),
        .out_b_ready (out_b_ready),
        .out_b_data  (out_b_data),
        .cnt_a       (cnt_a),
        .cnt_b       (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge and apply the channel rules to the queue model.
    task automatic step();
        bit do_push;
        bit pa;
        bit pb;
        logic s;
        logic [31:0] d;
        do_push = rst_n && !flush && in_valid && ((sel ? qb.size() : qa.size()) < 2);
        pa = rst_n && !flush && out_a_ready && (qa.size() > 0);
        pb = rst_n && !flush && out_b_ready && (qb.size() > 0);
        s = sel;
        d = in_data;
        @(posedge clk);
        if (!rst_n || flush) begin
            qa.delete(); qb.delete(); ma = 16'h0; mb = 16'h0;
        end else begin
            if (pa) void'(qa.pop_front());
            if (pb) void'(qb.pop_front());
            if (do_push) begin
                if (s) begin qb.push_back(d); mb = mb + 16'd1; end
                else   begin qa.push_back(d); ma = ma + 16'd1; end
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        flush = 0; in_valid = 0; in_data = 32'h0; sel = 0; out_a_ready = 0; out_b_ready = 0;
    endtask

    task automatic do_flush();
        idle_inputs(); flush = 1; step(); flush = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; idle_inputs(); in_valid = 1;
        #1;
        step(); step();
        tot++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        tot++; if ({out_a_valid, out_b_valid} !== 2'b00) begin bad++; $display("FAIL reset_valids got=%b exp=00", {out_a_valid, out_b_valid}); end
        tot++; if ({out_a_data, out_b_data} !== 64'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", {out_a_data, out_b_data}); end
        tot++; if ({cnt_a, cnt_b} !== 32'h0) begin bad++; $display("FAIL reset_cnt got=%h exp=0", {cnt_a, cnt_b}); end
        rst_n = 1; in_valid = 0;
    endtask

    task automatic test_single_a();
        in_valid = 1; sel = 0; in_data = 32'h1234_5678; out_a_ready = 1;
        #1;
        tot++; if (in_ready !== 1'b1) begin bad++; $display("FAIL single_ready got=%b exp=1", in_ready); end
        step(); in_valid = 0; #1;
        tot++; if (out_a_valid !== 1'b1 || out_a_data !== 32'h1234_5678) begin bad++; $display("FAIL single_out got=%b/%h exp=1/12345678", out_a_valid, out_a_data); end
        tot++; if (cnt_a !== 16'd1 || cnt_b !== 16'd0 || out_b_valid !== 1'b0) begin bad++; $display("FAIL single_cnt got=%h/%h/%b exp=1/0/0", cnt_a, cnt_b, out_b_valid); end
        step();
        tot++; if (out_a_valid !== 1'b0 || out_a_data !== 32'h0) begin bad++; $display("FAIL single_empty got=%b/%h exp=0/0", out_a_valid, out_a_data); end
    endtask

    task automatic test_stall_b();
        do_flush();
        sel = 1; in_valid = 1; out_b_ready = 0;
        in_data = 32'hA; step();
        in_data = 32'hB; step();
        in_data = 32'hC; #1;
        tot++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_full_ready got=%b exp=0", in_ready); end
        step(); step();
        tot++; if (out_b_data !== 32'hA || cnt_b !== 16'd2) begin bad++; $display("FAIL stall_hold got=%h/%h exp=a/2", out_b_data, cnt_b); end
        out_b_ready = 1; #1;
        tot++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_no_bypass got=%b exp=0", in_ready); end
        step();
        tot++; if (out_b_data !== 32'hB || in_ready !== 1'b1) begin bad++; $display("FAIL stall_second got=%h/%b exp=b/1", out_b_data, in_ready); end
        step(); in_valid = 0; #1;
        tot++; if (out_b_data !== 32'hC || cnt_b !== 16'd3) begin bad++; $display("FAIL stall_third got=%h/%h exp=c/3", out_b_data, cnt_b); end
        step();
        tot++; if (out_b_valid !== 1'b0) begin bad++; $display("FAIL stall_drain got=%b exp=0", out_b_valid); end
        out_b_ready = 0;
    endtask

    task automatic test_cross_full();
        do_flush();
        sel = 1; in_valid = 1;
        in_data = 32'h1111_0001; step();
        in_data = 32'h1111_0002; step();
        sel = 0; in_data = 32'h2222_0003; #1;
        tot++; if (in_ready !== 1'b1) begin bad++; $display("FAIL cross_ready got=%b exp=1", in_ready); end
        step(); in_valid = 0; sel = 1; #1;
        tot++; if (out_a_data !== 32'h2222_0003 || out_b_data !== 32'h1111_0001) begin bad++; $display("FAIL cross_data got=%h/%h exp=22220003/11110001", out_a_data, out_b_data); end
        tot++; if (in_ready !== 1'b0 || cnt_b !== 16'd2 || cnt_a !== 16'd1) begin bad++; $display("FAIL cross_bfull got=%b/%h/%h exp=0/2/1", in_ready, cnt_b, cnt_a); end
    endtask

    task automatic test_push_pop();
        do_flush();
        sel = 0; in_valid = 1; in_data = 32'hAAAA_0001; step();
        in_data = 32'hAAAA_0002; out_a_ready = 1; step();
        in_valid = 0; out_a_ready = 0; #1;
        tot++; if (out_a_valid !== 1'b1 || out_a_data !== 32'hAAAA_0002 || in_ready !== 1'b1) begin bad++; $display("FAIL pushpop_head got=%b/%h/%b exp=1/aaaa0002/1", out_a_valid, out_a_data, in_ready); end
        in_valid = 1; in_data = 32'hAAAA_0003; step(); in_valid = 0; #1;
        tot++; if (in_ready !== 1'b0 || out_a_data !== 32'hAAAA_0002) begin bad++; $display("FAIL pushpop_occ got=%b/%h exp=0/aaaa0002", in_ready, out_a_data); end
    endtask

    task automatic test_random();
        logic        e_rdy;
        logic [31:0] e_ad;
        logic [31:0] e_bd;
        for (int i = 0; i < 600; i++) begin
            flush       = ($urandom_range(0, 39) == 0);
            in_valid    = $urandom_range(0, 3) != 0;
            sel         = $urandom_range(0, 1);
            in_data     = $urandom;
            out_a_ready = $urandom_range(0, 2) != 0;
            out_b_ready = $urandom_range(0, 2) == 0;
            #1;
            e_rdy = !flush && ((sel ? qb.size() : qa.size()) < 2);
            e_ad  = (qa.size() > 0) ? qa[0] : 32'h0;
            e_bd  = (qb.size() > 0) ? qb[0] : 32'h0;
            tot++; if (in_ready !== e_rdy) begin bad++; $display("FAIL rand_ready i=%0d got=%b exp=%b", i, in_ready, e_rdy); end
            tot++; if (out_a_valid !== (qa.size() > 0) || out_a_data !== e_ad) begin bad++; $display("FAIL rand_a i=%0d got=%b/%h exp=%b/%h", i, out_a_valid, out_a_data, qa.size() > 0, e_ad); end
            tot++; if (out_b_valid !== (qb.size() > 0) || out_b_data !== e_bd) begin bad++; $display("FAIL rand_b i=%0d got=%b/%h exp=%b/%h", i, out_b_valid, out_b_data, qb.size() > 0, e_bd); end
            tot++; if (cnt_a !== ma || cnt_b !== mb) begin bad++; $display("FAIL rand_cnt i=%0d got=%h/%h exp=%h/%h", i, cnt_a, cnt_b, ma, mb); end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_wrap();
        do_flush();
        sel = 0; in_valid = 1; out_a_ready = 1;
        for (int i = 0; i < 65535; i++) begin
            in_data = $urandom;
            step();
        end
        tot++; if (cnt_a !== 16'hFFFF || cnt_a !== ma) begin bad++; $display("FAIL wrap_pre got=%h exp=ffff", cnt_a); end
        in_data = 32'hFEED_BEEF; step(); in_valid = 0; #1;
        tot++; if (cnt_a !== 16'h0000) begin bad++; $display("FAIL wrap_post got=%h exp=0000", cnt_a); end
        tot++; if (out_a_data !== 32'hFEED_BEEF) begin bad++; $display("FAIL wrap_last got=%h exp=feedbeef", out_a_data); end
        idle_inputs();
    endtask

    task automatic test_flush();
        do_flush();
        in_valid = 1;
        sel = 0; in_data = 32'h5; step();
        sel = 1; in_data = 32'h6; step();
        flush = 1; sel = 0; in_data = 32'h7; #1;
        tot++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b exp=0", in_ready); end
        step(); flush = 0; in_valid = 0; #1;
        tot++; if ({out_a_valid, out_b_valid} !== 2'b00 || {cnt_a, cnt_b} !== 32'h0) begin bad++; $display("FAIL flush_clear got=%b/%h exp=00/0", {out_a_valid, out_b_valid}, {cnt_a, cnt_b}); end
    endtask

    task automatic test_reset_mid();
        in_valid = 1;
        sel = 0; in_data = 32'h9; step();
        sel = 1; in_data = 32'hA; step();
        rst_n = 0; #1;
        tot++; if ({in_ready, out_a_valid, out_b_valid} !== 3'b000 || {out_a_data, out_b_data} !== 64'h0 || {cnt_a, cnt_b} !== 32'h0) begin
            bad++; $display("FAIL midreset got=%b%b%b/%h/%h exp=000/0/0", in_ready, out_a_valid, out_b_valid, {out_a_data, out_b_data}, {cnt_a, cnt_b});
        end
        step(); rst_n = 1; sel = 1; in_data = 32'hB0B0; #1;
        tot++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midreset_ready got=%b exp=1", in_ready); end
        step(); in_valid = 0; #1;
        tot++; if (out_b_valid !== 1'b1 || out_b_data !== 32'hB0B0 || cnt_b !== 16'd1) begin bad++; $display("FAIL midreset_first got=%b/%h/%h exp=1/b0b0/1", out_b_valid, out_b_data, cnt_b); end
    endtask

    initial begin
        tot = 0; bad = 0; ma = 16'h0; mb = 16'h0;
        test_reset();
        test_single_a();
        test_stall_b();
        test_cross_full();
        test_push_pop();
        test_random();
        test_flush();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end
endmodule

// File: doc/demux_32.md
DEMUX_32 -- requirements
Module: demux_32

Interface
REQ-001 SHALL have port clk, input, 1 bit, the single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-003 SHALL have port flush, input, 1 bit, synchronous clear of both channels and counters.
REQ-004 SHALL have port in_valid, input, 1 bit, producer offers in_data.
REQ-005 SHALL have port in_ready, output, 1 bit, block accepts in_data this cycle.
REQ-006 SHALL have port in_data, input, 32 bits, word to route.
REQ-007 SHALL have port sel, input, 1 bit, destination: 0 -> channel A, 1 -> channel B; sampled with in_data.
REQ-008 SHALL have ports out_a_valid (output, 1), out_a_ready (input, 1), out_a_data (output, 32), the channel A consumer handshake.
REQ-009 SHALL have ports out_b_valid (output, 1), out_b_ready (input, 1), out_b_data (output, 32), the channel B consumer handshake.
REQ-010 SHALL have ports cnt_a and cnt_b, output, 16 bits each, words accepted into A / B since reset or flush.

Function
REQ-011 SHALL hold one 2-entry FIFO per channel, occupancy 0..2, order preserved within a channel.
REQ-012 SHALL accept a word (push) on a rising edge where in_valid=1 and in_ready=1, writing it to the FIFO chosen by sel.
REQ-013 SHALL drive in_ready=1 iff flush=0 and the FIFO chosen by current sel holds fewer than 2 entries (combinational on sel, flush, occupancy); no same-cycle pop bypass at full.
REQ-014 SHALL pop channel X on a rising edge where out_x_valid=1 and out_x_ready=1.
REQ-015 SHALL drive out_x_valid=1 iff channel X occupancy >=1; out_x_data = head entry when valid, 32'h0 when empty.
REQ-016 SHALL give latency 1: word pushed at edge N is visible on out_x_valid/out_x_data from edge N onward if channel was empty.
REQ-017 SHALL, on simultaneous push and pop of the same channel at occupancy 1, keep occupancy 1 with the new word as head next cycle.
REQ-018 SHALL allow push to one channel and pop of the other in the same cycle independently.
REQ-019 SHALL never alter a channel's data, valid, or occupancy while it is stalled (out_x_ready=0) except by push to a non-full FIFO.
REQ-020 SHALL increment cnt_x by 1 on each push to channel X, wrapping 16'hFFFF -> 16'h0000.
REQ-021 SHALL, when flush=1 at a rising edge, set both occupancies to 0 and both counters to 0, ignoring any push/pop that cycle (flush has priority).
REQ-022 SHALL treat sel as don't-care when in_valid=0; the producer may change sel freely then.

Reset
REQ-023 SHALL, while rst_n=0 (asynchronously), force occupancies 0, out_a_valid=out_b_valid=0, out_a_data=out_b_data=32'h0, cnt_a=cnt_b=16'h0, in_ready=0.
REQ-024 SHALL, after rst_n deasserts, accept input from the first rising edge; reset mid-transfer discards all buffered words.

Verification
REQ-025 SHALL cover: reset, push 32'h1234_5678 with sel=0, out_a_ready=1 -> out_a_valid=1 one edge later with that data, then empty; cnt_a=1, B untouched.
REQ-026 SHALL cover: out_b_ready=0, push 32'hA, 32'hB, 32'hC to B -> in_ready=0 after second push; C not taken until B pops; order A,B,C observed; cnt_b=3.
REQ-027 SHALL cover: B full, sel=0 with in_valid=1 -> in_ready=1, word enters A; B contents unchanged.
REQ-028 SHALL cover: occupancy 1 on A, push+pop same edge -> occupancy 1, new word at head, no loss or duplication.
REQ-029 SHALL cover: cnt_a preloaded to 16'hFFFF by 65535 pushes, one more push -> cnt_a=16'h0000.
REQ-030 SHALL cover: both channels holding data, flush=1 with in_valid=1 -> both valids 0, counters 0, no word accepted; rst_n pulse mid-stream -> all outputs at reset values immediately.
